// File: rtl/jk_excitation_counter.sv
// jk_excitation_counter: modulo-MODULUS up/down counter built from JK flip-flops.
// The next state is chosen first. An excitation encoder then turns it into
// per-bit J/K values. Those J/K values are the only path into the state
// register, and they are exported for observation.
// Valid parameter range: 2 <= MODULUS <= 2**WIDTH.

// Single JK flip-flop, one per state bit.
module jk_ff (
  input  logic clock,
  input  logic reset_,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK characteristic: set, reset, hold, or toggle; async clear to 0
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) q <= 1'b0;
    else         q <= (j & ~q) | (~k & q);
  end

endmodule

module jk_excitation_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] data_load,
  output logic [WIDTH-1:0] jack_out,
  output logic [WIDTH-1:0] kilby_out,
  output logic [WIDTH-1:0] signal_q,
  output logic [WIDTH-1:0] signal_q_,
  output logic             carry
);

  // Terminal value. When MODULUS = 2**WIDTH this truncates to all ones, so
  // the count wraps naturally.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit, so MODULUS = 2**WIDTH is representable and the
  // out-of-range test is never true for a full-range counter.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             at_zero;
  logic             at_top;
  logic             out_of_range;

  assign at_zero      = (q == '0);
  assign at_top       = (q >= MAX_VAL);
  assign out_of_range = ({1'b0, q} >= MOD_EXT);

  // Target next state. Load takes priority over count, and count over hold.
  // Out-of-range states step back into range.
  always_comb begin
    target = q;
    if (load) begin
      target = data_load;
    end else if (enable) begin
      if (up) target = at_top ? '0 : q + WIDTH'(1);
      else    target = (at_zero || out_of_range) ? MAX_VAL : q - WIDTH'(1);
    end
  end

  // Excitation encoder. Don't-cares resolve to 0, so J=K=1 never occurs.
  always_comb begin
    j_vec = ~q & target;
    k_vec = q & ~target;
  end

  // One JK flip-flop per state bit. The state has no D path.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    jk_ff u_ff (
      .clock  (clock),
      .reset_ (reset_),
      .j      (j_vec[b]),
      .k      (k_vec[b]),
      .q      (q[b])
    );
  end

  assign carry     = ~load & enable & ((up & (q == MAX_VAL)) | (~up & at_zero));
  assign jack_out  = j_vec;
  assign kilby_out = k_vec;
  assign signal_q  = q;
  assign signal_q_ = ~q;

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Directed bench for jk_excitation_counter (WIDTH=4, MODULUS=10).
module tb_jk_excitation_counter;

  logic       clock = 1'b0;
  logic       reset_;
  logic       enable;
  logic       up;
  logic       load;
  logic [3:0] data_load;
  logic [3:0] jack_out;
  logic [3:0] kilby_out;
  logic [3:0] signal_q;
  logic [3:0] signal_q_;
  logic       carry;

  int total = 0;
  int bad   = 0;

  jk_excitation_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .enable    (enable),
    .up        (up),
    .load      (load),
    .data_load (data_load),
    .jack_out  (jack_out),
    .kilby_out (kilby_out),
    .signal_q  (signal_q),
    .signal_q_ (signal_q_),
    .carry     (carry)
  );

  always #5 clock = ~clock;

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let outputs settle
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check the state and its complement together
  task automatic chk_q(input string tag, input logic [3:0] exp);
    chk({tag, "_q"}, {4'h0, signal_q}, {4'h0, exp});
    chk({tag, "_qn"}, {4'h0, signal_q_}, {4'h0, ~exp});
  endtask

  initial begin
    logic [3:0] eq;
    reset_ = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; data_load = 4'h0;

    // Reset held across three edges
    repeat (3) tick();
    chk_q("rst", 4'h0);
    enable = 1'b1;
    #1;
    chk("rst_j_comb", {4'h0, jack_out}, 8'h01);
    reset_ = 1'b1;
    #1;
    chk("first_j", {4'h0, jack_out}, 8'h01);
    chk("first_k", {4'h0, kilby_out}, 8'h00);
    chk("first_carry", {7'h0, carry}, 8'h0);
    tick();
    chk_q("first", 4'h1);

    // Up count 1 → 9, then wrap. Carry is set only at 9.
    eq = 4'h1;
    for (int i = 0; i < 8; i++) begin
      chk("up_carry", {7'h0, carry}, {7'h0, (eq == 4'd9)});
      tick();
      eq = eq + 4'h1;
      chk_q("up", eq);
    end
    chk("wrap_carry", {7'h0, carry}, 8'h1);
    chk("wrap_j", {4'h0, jack_out}, 8'h00);
    chk("wrap_k", {4'h0, kilby_out}, 8'h09);
    tick();
    chk_q("wrap", 4'h0);

    // Down-borrow from 0
    up = 1'b0;
    #1;
    chk("borrow_carry", {7'h0, carry}, 8'h1);
    chk("borrow_j", {4'h0, jack_out}, 8'h09);
    tick();
    chk_q("borrow", 4'h9);
    chk("down9_carry", {7'h0, carry}, 8'h0);
    tick();
    chk_q("down8", 4'h8);
    tick();
    chk_q("down7", 4'h7);

    // Load priority at Q=5
    load = 1'b1; data_load = 4'h5; enable = 1'b0;
    tick();
    chk_q("ld5", 4'h5);
    enable = 1'b1; up = 1'b1; data_load = 4'h3;
    #1;
    chk("ldp_carry", {7'h0, carry}, 8'h0);
    chk("ldp_j", {4'h0, jack_out}, 8'h02);
    chk("ldp_k", {4'h0, kilby_out}, 8'h04);
    tick();
    chk_q("ldp", 4'h3);
    // Load at 9 while counting up masks the carry
    data_load = 4'h9;
    tick();
    chk_q("ld9", 4'h9);
    data_load = 4'h4;
    #1;
    chk("ld9_carry", {7'h0, carry}, 8'h0);
    tick();
    chk_q("ld4", 4'h4);

    // Out-of-range state
    data_load = 4'hC; enable = 1'b0;
    tick();
    chk_q("ldC", 4'hC);
    load = 1'b0;
    #1;
    chk("hold_j", {4'h0, jack_out}, 8'h00);
    chk("hold_k", {4'h0, kilby_out}, 8'h00);
    tick();
    chk_q("holdC", 4'hC);
    enable = 1'b1; up = 1'b1;
    #1;
    chk("oor_up_carry", {7'h0, carry}, 8'h0);
    chk("oor_up_k", {4'h0, kilby_out}, 8'h0C);
    tick();
    chk_q("oor_up", 4'h0);
    load = 1'b1; data_load = 4'hC;
    tick();
    chk_q("reldC", 4'hC);
    load = 1'b0; up = 1'b0;
    #1;
    chk("oor_dn_carry", {7'h0, carry}, 8'h0);
    chk("oor_dn_j", {4'h0, jack_out}, 8'h01);
    chk("oor_dn_k", {4'h0, kilby_out}, 8'h04);
    tick();
    chk_q("oor_dn", 4'h9);

    // Asynchronous reset between edges
    load = 1'b1; data_load = 4'h7;
    tick();
    chk_q("ld7", 4'h7);
    load = 1'b0; up = 1'b1; enable = 1'b1;
    #2;
    reset_ = 1'b0;
    #1;
    chk_q("arst", 4'h0);
    #1;
    reset_ = 1'b1;
    tick();
    chk_q("post_rst", 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_excitation_counter.md
# jk_excitation_counter

Synchronous modulo-N up/down counter whose state bits are edge-triggered JK flip-flops driven by an excitation encoder: the encoder takes the desired next state and produces the J/K inputs for each bit, the reverse of the JK characteristic (J/K in, Q out). It is the JK-based counter stage of the experiment 6 sequential designs. The J/K vectors are exported so the bench can check the excitation table directly.

## Interface
- WIDTH, 4: state width in bits.
- MODULUS, 10: count modulus. Must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.

- clock  input  1  rising-edge clock; the only clock.
- reset_  input  1  asynchronous, active-low reset.
- enable  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load; takes priority over enable.
- data_load  input  WIDTH  value captured on load.
- jack_out  output  WIDTH  J excitation currently applied to each state bit.
- kilby_out  output  WIDTH  K excitation currently applied to each state bit.
- signal_q  output  WIDTH  counter state.
- signal_q_  output  WIDTH  bitwise complement of signal_q, always.
- carry  output  1  terminal-count flag: wrap or borrow occurs on the next edge.

## Operation
- State register: WIDTH JK flip-flops. Per bit, on the clock edge: Q+ = (J & ~Q) | (~K & Q).
- Target next state T. Priority is load, then count, then hold:
  - load=1: T = data_load, regardless of enable and up.
  - load=0, enable=1, up=1: T = 0 if Q ≥ MODULUS-1, else Q+1.
  - load=0, enable=1, up=0: T = MODULUS-1 if Q = 0 or Q ≥ MODULUS, else Q-1.
  - Otherwise: T = Q.
- Excitation encoder, per bit. Don't-cares resolve to 0:
  - J = ~Q & T
  - K = Q & ~T
  - Consequence: hold gives J=K=0 on every bit; J=K=1 never occurs.
- The register is updated only through J/K. No direct D path to Q.
- Out-of-range state (Q ≥ MODULUS, possible only via load): data_load is captured unmodified. Counting up from it goes to 0. Counting down from it goes to MODULUS-1. Holding keeps it.
- carry = ~load & enable & ((up & Q = MODULUS-1) | (~up & Q = 0)). It is combinational and low during load.
- Arithmetic is WIDTH bits wide. Comparisons are unsigned. MODULUS = 2^WIDTH must produce a natural binary wrap.

## Timing
- Reset (reset_=0): signal_q=0, signal_q_=all ones, immediately and independent of clock. During reset, jack_out, kilby_out and carry equal the values computed from Q=0 and the current inputs.
- Reset mid-count clears the state at once. The first edge after reset_ rises acts on Q=0.
- Latency: one edge. T, J and K are computed in the cycle before the edge; Q shows T right after the edge.
- jack_out, kilby_out and carry are combinational from Q and the controls. They are valid before each edge and change only when Q or the inputs change.
- If load and enable are both high on the same edge, load wins and no carry is flagged.
- Direction can change on any cycle. The step uses the value of up sampled at that edge.
- Only the counter state is registered. There is no other state.

## Test plan
- Reset: hold reset_=0 and pulse clock 3 times → signal_q=0, signal_q_=4'hF. Release, set enable=1, up=1, clock once → signal_q=1, and before the edge jack_out=4'b0001, kilby_out=0.
- Up-wrap with MODULUS=10: count from 0 over 10 edges → 1..9, 0. carry=1 only while Q=9. At Q=9→0, jack_out=0 and kilby_out=4'b1001.
- Down-borrow: from Q=0, up=0, enable=1 → carry=1 before the edge; next Q=9; then 8, 7.
- Load priority: Q=5, load=1, enable=1, data_load=3 → Q=3 and carry=0. Check jack_out=4'b0010, kilby_out=4'b0100.
- Out-of-range: load 4'hC. With enable=0, Q stays 12 and J=K=0. One up step → 0. Reload 12, one down step → 9.
- Async reset mid-count: at Q=7, drop reset_ between edges → Q=0 immediately. Release, then count up → 1.
